// File: rtl/lab3_cache_linexferengine_if.sv
// Bundle of the line-transfer engine's handshake streams: the line command,
// the memory request and response streams, and the line completion result.
//   master : command issuer / memory / result consumer side (cache datapath)
//   slave  : the transfer engine itself
// Widths: AW = address, WW = memory word, LW = whole line, IW = word index.
interface lab3_cache_linexferengine_if #(
    parameter int p_addr_nbits = 32,
    parameter int p_word_nbits = 32,
    parameter int p_line_words = 16
);
    localparam int AW = p_addr_nbits;
    localparam int WW = p_word_nbits;
    localparam int LW = p_line_words * p_word_nbits;
    localparam int IW = $clog2(p_line_words);

    // line command
    logic          cmd_val;
    logic          cmd_rdy;
    logic [1:0]    cmd_mode;
    logic [AW-1:0] cmd_victim_addr;
    logic [AW-1:0] cmd_refill_addr;
    logic [LW-1:0] cmd_victim_line;
    // memory request
    logic          memreq_val;
    logic          memreq_rdy;
    logic          memreq_type;
    logic [AW-1:0] memreq_addr;
    logic [WW-1:0] memreq_data;
    logic [IW-1:0] memreq_opaque;
    // memory response
    logic          memresp_val;
    logic          memresp_rdy;
    logic          memresp_type;
    logic [IW-1:0] memresp_opaque;
    logic [WW-1:0] memresp_data;
    // completion
    logic          line_val;
    logic          line_rdy;
    logic [LW-1:0] line_data;

    modport master (
        output cmd_val, cmd_mode, cmd_victim_addr, cmd_refill_addr, cmd_victim_line,
        input  cmd_rdy,
        input  memreq_val, memreq_type, memreq_addr, memreq_data, memreq_opaque,
        output memreq_rdy,
        output memresp_val, memresp_type, memresp_opaque, memresp_data,
        input  memresp_rdy,
        input  line_val, line_data,
        output line_rdy
    );

    modport slave (
        input  cmd_val, cmd_mode, cmd_victim_addr, cmd_refill_addr, cmd_victim_line,
        output cmd_rdy,
        output memreq_val, memreq_type, memreq_addr, memreq_data, memreq_opaque,
        input  memreq_rdy,
        input  memresp_val, memresp_type, memresp_opaque, memresp_data,
        output memresp_rdy,
        output line_val, line_data,
        input  line_rdy
    );
endinterface

// File: rtl/lab3_cache_linexferengine.sv
// Cache line-transfer engine. Takes one line command (REFILL, WRITEBACK or
// EVICT = writeback then refill) and sequences word-granular memory traffic
// with up to p_max_inflight outstanding requests. Read responses may return
// in any order; they are steered into the line buffer by their word index.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   xif.slave  : cmd_*    line command in (victim line captured on fire)
//                memreq_* word requests out, opaque = word index
//                memresp_* word responses in
//                line_*   completion with refilled line (zero for WRITEBACK)
// All handshake outputs decode registered state only; no input-to-output paths.
module lab3_cache_linexferengine #(
    parameter int p_addr_nbits   = 32,
    parameter int p_word_nbits   = 32,
    parameter int p_line_words   = 16,
    parameter int p_max_inflight = 4
) (
    input  logic clk,
    input  logic reset,
    lab3_cache_linexferengine_if.slave xif
);
    localparam int AW = p_addr_nbits;
    localparam int WW = p_word_nbits;
    localparam int IW = $clog2(p_line_words);
    localparam int BO = $clog2(p_word_nbits / 8);
    localparam int CW = $clog2(p_max_inflight + 1);
    localparam logic [AW-1:0] BASE_MASK = ~((AW'(1) << (IW + BO)) - AW'(1));

    typedef enum logic [2:0] {IDLE, WB_REQ, WB_DRAIN, RF_REQ, RF_DRAIN, RESP} state_t;

    state_t                         state;
    logic                           do_refill;
    logic                           cmd_rdy_q;
    logic                           line_val_q;
    logic [IW-1:0]                  idx;
    logic [CW-1:0]                  inflight;
    logic [AW-1:0]                  victim_base;
    logic [AW-1:0]                  refill_base;
    logic [p_line_words-1:0][WW-1:0] victim_buf;
    logic [p_line_words-1:0][WW-1:0] line_buf;

    logic in_req, in_xfer, req_fire, resp_fire, cmd_fire, last_idx, wb_done;

    assign in_req    = (state == WB_REQ) || (state == RF_REQ);
    assign in_xfer   = in_req || (state == WB_DRAIN) || (state == RF_DRAIN);
    assign req_fire  = xif.memreq_val && xif.memreq_rdy;
    assign resp_fire = xif.memresp_val && xif.memresp_rdy;
    assign cmd_fire  = xif.cmd_val && cmd_rdy_q;
    assign last_idx  = (idx == IW'(p_line_words - 1));
    // Writeback drain hands off to the refill on the edge that takes the final
    // ack, so the first read still issues strictly after every write is acked.
    assign wb_done   = (inflight == '0) || ((inflight == CW'(1)) && resp_fire);

    assign xif.cmd_rdy        = cmd_rdy_q;
    assign xif.memreq_val     = in_req && (inflight < CW'(p_max_inflight));
    assign xif.memreq_type    = (state == WB_REQ);
    assign xif.memreq_addr    = ((state == WB_REQ) ? victim_base : refill_base)
                                + (AW'(idx) << BO);
    assign xif.memreq_data    = (state == WB_REQ) ? victim_buf[idx] : '0;
    assign xif.memreq_opaque  = idx;
    assign xif.memresp_rdy    = in_xfer && (inflight != '0);
    assign xif.line_val       = line_val_q;
    assign xif.line_data      = line_buf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            do_refill   <= 1'b0;
            cmd_rdy_q   <= 1'b1;
            line_val_q  <= 1'b0;
            idx         <= '0;
            inflight    <= '0;
            victim_base <= '0;
            refill_base <= '0;
            victim_buf  <= '0;
            line_buf    <= '0;
        end else begin
            if (req_fire && !resp_fire)
                inflight <= inflight + CW'(1);
            else if (resp_fire && !req_fire)
                inflight <= inflight - CW'(1);

            if (resp_fire && !xif.memresp_type)
                line_buf[xif.memresp_opaque] <= xif.memresp_data;

            // idx wraps to 0 after the last word, ready for the next phase
            if (req_fire)
                idx <= idx + IW'(1);

            case (state)
                IDLE: if (cmd_fire) begin
                    victim_base <= xif.cmd_victim_addr & BASE_MASK;
                    refill_base <= xif.cmd_refill_addr & BASE_MASK;
                    victim_buf  <= xif.cmd_victim_line;
                    line_buf    <= '0;
                    idx         <= '0;
                    do_refill   <= (xif.cmd_mode != 2'd1);
                    cmd_rdy_q   <= 1'b0;
                    state       <= (xif.cmd_mode == 2'd1 || xif.cmd_mode == 2'd2)
                                   ? WB_REQ : RF_REQ;
                end
                WB_REQ: if (req_fire && last_idx) state <= WB_DRAIN;
                WB_DRAIN: if (wb_done) begin
                    if (do_refill) begin
                        state <= RF_REQ;
                    end else begin
                        state      <= RESP;
                        line_val_q <= 1'b1;
                    end
                end
                RF_REQ: if (req_fire && last_idx) state <= RF_DRAIN;
                RF_DRAIN: if (inflight == '0) begin
                    state      <= RESP;
                    line_val_q <= 1'b1;
                end
                RESP: if (xif.line_rdy) begin
                    state      <= IDLE;
                    line_val_q <= 1'b0;
                    cmd_rdy_q  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
